// File: rtl/seg_scan_pkg.sv
// Shared definitions for the 7-seg scan bus (also used by the display scanner).
package seg_scan_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int DIGIT_W    = 4;
  localparam int AN_W       = 3;

  typedef logic [DIGIT_W-1:0] digit_t;
  typedef logic [AN_W-1:0]    an_t;

  // One registered bus sample: digit select plus nibble.
  typedef struct packed {
    an_t    an;
    digit_t data;
  } scan_smp_t;

  // One-hot decode of a digit select.
  function automatic logic [NUM_DIGITS-1:0] digit_onehot(input an_t a);
    logic [NUM_DIGITS-1:0] r;
    r    = '0;
    r[a] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/seg_digit_age.sv
// Per-digit saturating age counter. stale rises when the digit has gone
// TIMEOUT cycles without a commit and drops on the next commit.
module seg_digit_age #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic stale
);

  localparam int AGE_W = $clog2(TIMEOUT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT);

  logic [AGE_W-1:0] age_q, age_d;
  logic             stale_q, stale_d;

  // Next age/stale: disabled digits idle at zero, clear beats saturation.
  always_comb begin
    age_d   = age_q;
    stale_d = stale_q;
    if (!enable || clear) begin
      age_d   = '0;
      stale_d = 1'b0;
    end else begin
      if (age_q < AGE_MAX) begin
        age_d = age_q + 1'b1;
      end
      stale_d = (age_d == AGE_MAX);
    end
  end

  // Age/stale registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      age_q   <= '0;
      stale_q <= 1'b0;
    end else begin
      age_q   <= age_d;
      stale_q <= stale_d;
    end
  end

  assign stale = stale_q;

endmodule

// File: rtl/seg_scan_capture.sv
// Reader for the time-multiplexed 7-seg scan bus: debounces digit switches,
// keeps the last committed nibble per digit, and flags frames, bad digit
// addresses and digits that stopped being refreshed.
module seg_scan_capture
  import seg_scan_pkg::*;
#(
  parameter int                    STABLE_CYCLES = 4,
  parameter logic [NUM_DIGITS-1:0] DIGIT_MASK    = 8'hF5,
  parameter int                    TIMEOUT       = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [AN_W-1:0]               scan_an,
  input  logic [DIGIT_W-1:0]            scan_data,
  output logic [NUM_DIGITS*DIGIT_W-1:0] digits,
  output logic [NUM_DIGITS-1:0]         valid,
  output logic [NUM_DIGITS-1:0]         stale,
  output logic                          frame_done,
  output logic                          bad_addr
);

  localparam int DWELL_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [DWELL_W-1:0] DWELL_SAT = DWELL_W'(STABLE_CYCLES);

  scan_smp_t                            smp_q, smp_d;
  logic [DWELL_W-1:0]                   dwell_q, dwell_d;
  logic                                 changed;
  logic                                 commit;
  logic [NUM_DIGITS-1:0]                commit_bit;
  logic                                 commit_ok;
  logic                                 commit_bad;
  logic [NUM_DIGITS-1:0]                commit_clr;

  logic [NUM_DIGITS-1:0][DIGIT_W-1:0]   digits_q, digits_d;
  logic [NUM_DIGITS-1:0]                valid_q, valid_d;
  logic [NUM_DIGITS-1:0]                seen_q, seen_d;
  logic                                 frame_q, frame_d;
  logic                                 bad_q, bad_d;

  // Sample/dwell tracking. The commit uses the incoming sample so that a
  // dwell of STABLE_CYCLES=1 still writes the value that just arrived.
  always_comb begin
    smp_d   = {scan_an, scan_data};
    changed = (smp_d != smp_q);
    dwell_d = dwell_q;
    if (changed) begin
      dwell_d = DWELL_W'(1);
    end else if (dwell_q != DWELL_SAT) begin
      dwell_d = dwell_q + 1'b1;
    end
    // Fire only on the edge the dwell reaches saturation, once per dwell.
    commit = (dwell_d == DWELL_SAT) && (changed || (dwell_q != DWELL_SAT));
  end

  // Commit decode against the expected-digit mask.
  always_comb begin
    commit_bit = digit_onehot(smp_d.an);
    commit_ok  = commit && ((commit_bit & DIGIT_MASK) != '0);
    commit_bad = commit && !commit_ok;
    commit_clr = commit_ok ? commit_bit : '0;
  end

  // Digit register file, valid flags and frame tracking.
  always_comb begin
    digits_d = digits_q;
    valid_d  = valid_q;
    seen_d   = seen_q;
    frame_d  = 1'b0;
    bad_d    = commit_bad;
    if (commit_ok) begin
      digits_d[smp_d.an] = smp_d.data;
      valid_d            = valid_q | commit_bit;
      // The completing digit is not carried into the next frame.
      if ((seen_q | commit_bit) == DIGIT_MASK) begin
        frame_d = 1'b1;
        seen_d  = '0;
      end else begin
        seen_d  = seen_q | commit_bit;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      smp_q    <= '0;
      dwell_q  <= '0;
      digits_q <= '0;
      valid_q  <= '0;
      seen_q   <= '0;
      frame_q  <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      smp_q    <= smp_d;
      dwell_q  <= dwell_d;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      seen_q   <= seen_d;
      frame_q  <= frame_d;
      bad_q    <= bad_d;
    end
  end

  // One age tracker per digit; unmasked digits stay idle.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_age
      seg_digit_age #(
        .TIMEOUT (TIMEOUT)
      ) u_age (
        .clk    (clk),
        .rst    (rst),
        .enable (DIGIT_MASK[gi]),
        .clear  (commit_clr[gi]),
        .stale  (stale[gi])
      );
    end
  endgenerate

  assign digits     = digits_q;
  assign valid      = valid_q;
  assign frame_done = frame_q;
  assign bad_addr   = bad_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture: directed scenarios plus random bus traffic,
// all outputs compared every cycle against an event-level reference model.
module tb_seg_scan_capture;

  localparam int          S    = 4;
  localparam logic [7:0]  MASK = 8'hF5;
  localparam int          T    = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  scan_an;
  logic [3:0]  scan_data;
  logic [31:0] digits;
  logic [7:0]  valid;
  logic [7:0]  stale;
  logic        frame_done;
  logic        bad_addr;

  always #5 clk = ~clk;

  seg_scan_capture #(
    .STABLE_CYCLES (S),
    .DIGIT_MASK    (MASK),
    .TIMEOUT       (T)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .scan_an    (scan_an),
    .scan_data  (scan_data),
    .digits     (digits),
    .valid      (valid),
    .stale      (stale),
    .frame_done (frame_done),
    .bad_addr   (bad_addr)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model: a value commits when it has been on the bus for
  // exactly S consecutive edges; staleness is time since last commit.
  int         cyc;
  int         run;
  logic [6:0] prev;
  logic [3:0] m_dig [8];
  logic [7:0] m_valid;
  int         m_last [8];
  logic [7:0] m_seen;
  logic       m_frame;
  logic       m_bad;
  int         obs_frames = 0;
  int         obs_bads   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge();
    logic [6:0] cur;
    int         a;
    if (rst) begin
      cyc = 0; run = 0; prev = '0;
      for (int i = 0; i < 8; i++) begin m_dig[i] = '0; m_last[i] = 0; end
      m_valid = '0; m_seen = '0; m_frame = 1'b0; m_bad = 1'b0;
    end else begin
      cyc++;
      m_frame = 1'b0;
      m_bad   = 1'b0;
      cur = {scan_an, scan_data};
      run = (cur == prev) ? run + 1 : 1;
      prev = cur;
      if (run == S) begin
        a = int'(scan_an);
        if (MASK[a]) begin
          m_dig[a]   = scan_data;
          m_valid[a] = 1'b1;
          m_last[a]  = cyc;
          if ((m_seen | (8'(1) << a)) == MASK) begin
            m_frame = 1'b1;
            m_seen  = '0;
          end else begin
            m_seen[a] = 1'b1;
          end
        end else begin
          m_bad = 1'b1;
        end
      end
    end
  endtask

  task automatic tick();
    logic [31:0] ed;
    logic [7:0]  es;
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < 8; i++) begin
      ed[4*i +: 4] = m_dig[i];
      es[i] = MASK[i] && ((cyc - m_last[i]) >= T);
    end
    check("digits", digits, ed);
    check("valid", {24'd0, valid}, {24'd0, m_valid});
    check("stale", {24'd0, stale}, {24'd0, es});
    check("frame_done", {31'd0, frame_done}, {31'd0, m_frame});
    check("bad_addr", {31'd0, bad_addr}, {31'd0, m_bad});
    obs_frames += int'(frame_done);
    obs_bads   += int'(bad_addr);
  endtask

  task automatic drive(input int an, input int data, input int n);
    scan_an   = 3'(an);
    scan_data = 4'(data);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int f0, b0, nxt;
  int seq_an [6] = '{0, 2, 4, 5, 6, 7};
  int seq_d1 [6] = '{3, 7, 1, 0, 1, 1};
  int part [5]   = '{0, 2, 4, 5, 6};

  initial begin
    rst = 1'b1; scan_an = '0; scan_data = '0;
    tick(); tick();
    rst = 1'b0;
    check("reset_digits", digits, 32'd0);
    check("reset_flags", {valid, stale, 6'd0, frame_done, bad_addr}, 24'd0);
    $display("step 0: reset checked");

    // 1: full frame 0:3 2:7 4:1 5:0 6:1 7:1
    f0 = obs_frames;
    for (int i = 0; i < 6; i++) drive(seq_an[i], seq_d1[i], 6);
    check("t1_digits", digits, 32'h1101_0703);
    check("t1_valid", {24'd0, valid}, 32'h0000_00F5);
    check("t1_frames", obs_frames - f0, 1);
    $display("step 1: frame scan digits=%h valid=%h", digits, valid);

    // 2: short 2:9 dwell rejected, 2:A commits
    for (int i = 0; i < 3; i++) begin
      drive(2, 9, 1);
      check("t2_no9", {31'd0, digits[11:8] == 4'h9}, 32'd0);
    end
    drive(2, 10, 3);
    check("t2_before", {28'd0, digits[11:8]}, 32'h7);
    drive(2, 10, 1);
    check("t2_after", {28'd0, digits[11:8]}, 32'hA);
    drive(2, 10, 2);
    $display("step 2: glitch rejected digit2=%h", digits[11:8]);

    // 3: unmasked digit 1
    f0 = obs_frames; b0 = obs_bads;
    drive(1, 15, 6);
    check("t3_bad_pulses", obs_bads - b0, 1);
    check("t3_digit1", {28'd0, digits[7:4]}, 32'd0);
    check("t3_valid1", {31'd0, valid[1]}, 32'd0);
    check("t3_frames", obs_frames - f0, 0);
    $display("step 3: bad address pulses=%0d", obs_bads - b0);

    // 4: digit 7 never refreshed goes stale
    do_reset();
    nxt = 0;
    while (cyc < 1100) begin
      drive(part[nxt], int'($urandom_range(0, 15)), 6);
      nxt = (nxt + 1) % 5;
    end
    check("t4_stale", {24'd0, stale}, 32'h80);
    f0 = obs_frames;
    drive(7, int'($urandom_range(0, 15)), 6);
    check("t4_stale_clr", {24'd0, stale}, 32'd0);
    check("t4_frame", obs_frames - f0, 1);
    $display("step 4: stale after refresh=%h", stale);

    // 5: reset mid-dwell, then full rescan
    do_reset();
    for (int i = 0; i < 3; i++) drive(seq_an[i], i + 4, 6);
    drive(5, 9, 2);
    do_reset();
    check("t5_rst_digits", digits, 32'd0);
    check("t5_rst_flags", {valid, stale, 6'd0, frame_done, bad_addr}, 24'd0);
    f0 = obs_frames;
    for (int i = 0; i < 5; i++) drive(seq_an[i], i + 1, 6);
    check("t5_no_early_frame", obs_frames - f0, 0);
    drive(7, 8, 6);
    check("t5_frame", obs_frames - f0, 1);
    $display("step 5: reset recovery frames=%0d", obs_frames - f0);

    // 6: digit-7 commit lands on the timeout edge
    do_reset();
    scan_an = 3'd0; scan_data = 4'd5;
    while (cyc < 1020) tick();
    drive(7, 9, 4);
    check("t6_commit_cycle", cyc, 1024);
    check("t6_stale7", {31'd0, stale[7]}, 32'd0);
    check("t6_valid7", {31'd0, valid[7]}, 32'd1);
    drive(7, 9, 3);
    check("t6_stale7_after", {31'd0, stale[7]}, 32'd0);
    $display("step 6: commit vs timeout stale=%h", stale);

    // 7: random traffic
    do_reset();
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      if ($urandom_range(0, 3) != 0)
        drive(part[$urandom_range(0, 4)] + (($urandom_range(0, 5) == 0) ? 1 : 0),
              int'($urandom_range(0, 15)), int'($urandom_range(1, 7)));
      else
        drive(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
              int'($urandom_range(1, 7)));
    end
    $display("step 7: random traffic frames=%0d bads=%0d", obs_frames, obs_bads);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
